// File: rtl/sub16_serial_pkg.sv
// Shared definitions for the serial add/sub family: default widths and FSM encodings.
package sub16_serial_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultSlice = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sub16_serial_fa4_slice.sv
// Combinational 4-bit full-adder slice reused once per clock by the serial datapath.
module fa4_slice
  import sub16_serial_pkg::*;
#(
  parameter int unsigned W = DefaultSlice
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Widen by one bit so the carry-out falls out of the addition.
  always_comb begin
    {cout, s} = (W+1)'(x) + (W+1)'(y) + (W+1)'(cin);
  end

endmodule

// File: rtl/sub16_serial.sv
// Multi-cycle subtractor: diff = a + ~b + 1, one SLICE-bit slice per clock, valid/ready on both
// sides. borrow is the inverted final carry.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SLICE = DefaultSlice
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned NSLICES = WIDTH / SLICE;
  localparam int unsigned IdxW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICES - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  nb_q, nb_d;     // subtrahend stored already inverted
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;

  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;

  // Operands are shifted right each RUN cycle so the active slice is always the low bits.
  fa4_slice #(
    .W (SLICE)
  ) u_slice (
    .x    (a_q[SLICE-1:0]),
    .y    (nb_q[SLICE-1:0]),
    .cin  (carry_q),
    .s    (slice_sum),
    .cout (slice_cout)
  );

  // Next-state logic for the FSM, operand shifters, carry chain and result registers.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> SLICE;
        nb_d    = nb_q >> SLICE;
        diff_d[idx_q*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          borrow_d = ~slice_cout;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      nb_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b1;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Handshake flags are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    diff      = diff_q;
    borrow    = borrow_q;
  end

endmodule

// File: tb/tb_sub16_serial.sv
module tb_sub16_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  sub16_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  // Reference: signed integer difference, borrow when negative, diff wrapped into 16 bits.
  function automatic logic [16:0] ref_model(input logic [15:0] x, input logic [15:0] y);
    int d;
    int w;
    d = int'(x) - int'(y);
    w = (d + 65536) % 65536;
    return {d < 0, w[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed operation: accept, measure latency, optionally stall, then hand off.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input int stall);
    logic [16:0] e;
    int lat;
    e = ref_model(x, y);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    cycle();
    in_valid = 1'b0;
    a = 16'h0;
    b = 16'h0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(diff), 32'(e[15:0]));
    check({tag, "_borrow"}, 32'(borrow), 32'(e[16]));
    for (int i = 0; i < stall; i++) begin
      cycle();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_diff"}, 32'(diff), 32'(e[15:0]));
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int low_cnt;
    int cyc;
    bit got;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [16:0] e;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h0;
    b = 16'h0;
    @(negedge clk);
    cycle();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    cycle();

    // Basic subtract with out_ready held high: in_ready low for exactly 5 samples.
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'd4;
    b = 16'd3;
    cycle();
    in_valid = 1'b0;
    lat = -1;
    low_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (!in_ready) low_cnt++;
      if (out_valid && lat < 0) begin
        lat = k;
        check("basic_diff", 32'(diff), 32'd1);
        check("basic_borrow", 32'(borrow), 32'd0);
      end
      cycle();
    end
    out_ready = 1'b0;
    check("basic_latency", 32'(lat), 32'd4);
    check("basic_ready_low", 32'(low_cnt), 32'd5);

    run_op("under1", 16'd3, 16'd4, 0);
    run_op("under2", 16'd0, 16'd1, 0);
    run_op("mix1", 16'd500, 16'd125, 1);
    run_op("mix2", 16'd9000, 16'd500, 0);
    run_op("eq_max", 16'd65535, 16'd65535, 0);
    run_op("zero_max", 16'd0, 16'd65535, 2);

    // Backpressure: result held for 10 cycles while a second request is ignored.
    in_valid = 1'b1;
    a = 16'd5000;
    b = 16'd36;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 16'd1;
      b = 16'd2;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_diff", 32'(diff), 32'd4964);
      check("bp_borrow", 32'(borrow), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("bp_post_valid", 32'(out_valid), 32'd0);
    check("bp_post_ready", 32'(in_ready), 32'd1);
    cycle();
    out_ready = 1'b0;
    check("bp_single", 32'(out_valid), 32'd0);

    // Reset on the second RUN cycle aborts the operation.
    in_valid = 1'b1;
    a = 16'd36;
    b = 16'd56;
    cycle();
    in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_diff", 32'(diff), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (out_valid) check("rst_mid_no_result", 32'(out_valid), 32'd0);
      cycle();
    end
    run_op("after_rst", 16'd56, 16'd36, 0);

    // Random regression with random output stalls, scored in order.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 10 == 0) rb = ra;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
        cycle();
        cyc++;
      end
      in_valid = 1'b1;
      a = ra;
      b = rb;
      exp_q.push_back(ref_model(ra, rb));
      cycle();
      in_valid = 1'b0;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 50) begin
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
          check("rand_result", 32'({borrow, diff}), 32'(e));
          got = 1'b1;
        end
        cycle();
        cyc++;
      end
      out_ready = 1'b0;
      if (!got) check("rand_timeout", 32'd0, 32'd1);
    end
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rand_final_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
